// File: rtl/mem_stage_lsu_pkg.sv
// Shared definitions for the MEM stage: load-op encodings and bus field widths.
package mem_stage_lsu_pkg;

    localparam int LD_OP_W = 3;

    typedef enum logic [LD_OP_W-1:0] {
        LD_W  = 3'b000,
        LD_B  = 3'b001,
        LD_BU = 3'b010,
        LD_H  = 3'b011,
        LD_HU = 3'b100
    } ld_op_e;

    // Flag bits in the EX->MEM bus above dest: gr_we, res_from_mem, mem_req.
    localparam int ES_FLAG_W = 3;

endpackage

// File: rtl/mem_stage_lsu_load_align.sv
// Sub-word load extraction: selects a byte/halfword from the memory word and extends it.
module mem_stage_lsu_load_align
    import mem_stage_lsu_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0]  raw,
    input  logic [1:0]         a,
    input  logic [LD_OP_W-1:0] ld_op,
    output logic [DATA_W-1:0]  extracted
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel  = raw[{a, 3'b000} +: 8];
        half_sel  = a[1] ? raw[31:16] : raw[15:0];
        extracted = raw;
        case (ld_op)
            LD_B:    extracted = {{(DATA_W-8){byte_sel[7]}}, byte_sel};
            LD_BU:   extracted = {{(DATA_W-8){1'b0}}, byte_sel};
            LD_H:    extracted = {{(DATA_W-16){half_sel[15]}}, half_sel};
            LD_HU:   extracted = {{(DATA_W-16){1'b0}}, half_sel};
            default: extracted = raw;
        endcase
    end

endmodule

// File: rtl/mem_stage_lsu.sv
// MEM pipeline stage: waits on split-phase data-SRAM responses, buffers load data under
// WB back-pressure, and drops responses that belong to flushed instructions.
module mem_stage_lsu
    import mem_stage_lsu_pkg::*;
#(
    parameter int PC_W   = 32,
    parameter int DATA_W = 32,
    parameter int RF_AW  = 5,
    parameter int CNT_W  = 2,
    localparam int ES_W  = LD_OP_W + ES_FLAG_W + RF_AW + DATA_W + PC_W,
    localparam int MS_W  = 1 + RF_AW + DATA_W + PC_W
) (
    input  logic                      clk,
    input  logic                      resetn,
    input  logic                      ws_allowin,
    output logic                      ms_allowin,
    input  logic                      es_to_ms_valid,
    input  logic [ES_W-1:0]           es_to_ms_bus,
    input  logic                      ms_flush,
    input  logic                      data_sram_data_ok,
    input  logic [DATA_W-1:0]         data_sram_rdata,
    output logic                      ms_to_ws_valid,
    output logic [MS_W-1:0]           ms_to_ws_bus,
    output logic [RF_AW+DATA_W+1:0]   ms_to_ds_bus
);

    if (DATA_W != 32) begin : g_bad_width
        $error("mem_stage_lsu: DATA_W must be 32");
    end

    localparam int OFF_ALU  = PC_W;
    localparam int OFF_DEST = PC_W + DATA_W;
    localparam int OFF_WE   = OFF_DEST + RF_AW;
    localparam int OFF_RFM  = OFF_WE + 1;
    localparam int OFF_MREQ = OFF_WE + 2;
    localparam int OFF_LDOP = OFF_WE + 3;

    logic [ES_W-1:0]    bus_r;
    logic               ms_valid;
    logic               buf_valid;
    logic [DATA_W-1:0]  buf_data;
    logic [CNT_W-1:0]   cancel_cnt;

    logic [PC_W-1:0]    pc;
    logic [DATA_W-1:0]  alu_result;
    logic [RF_AW-1:0]   dest;
    logic               gr_we;
    logic               res_from_mem;
    logic               mem_req;
    logic [LD_OP_W-1:0] ld_op;

    logic               data_ok_acc;
    logic               cnt_inc;
    logic               cnt_dec;
    logic               done;
    logic               we;
    logic [DATA_W-1:0]  raw;
    logic [DATA_W-1:0]  extracted;
    logic [DATA_W-1:0]  final_result;

    assign pc           = bus_r[PC_W-1:0];
    assign alu_result   = bus_r[OFF_ALU +: DATA_W];
    assign dest         = bus_r[OFF_DEST +: RF_AW];
    assign gr_we        = bus_r[OFF_WE];
    assign res_from_mem = bus_r[OFF_RFM];
    assign mem_req      = bus_r[OFF_MREQ];
    assign ld_op        = bus_r[OFF_LDOP +: LD_OP_W];

    // A pulse arriving while cancels are owed belongs to a flushed instruction.
    assign cnt_dec     = data_sram_data_ok & (cancel_cnt != '0);
    assign data_ok_acc = data_sram_data_ok & (cancel_cnt == '0);
    assign done        = !mem_req | buf_valid | data_ok_acc;
    assign cnt_inc     = ms_flush & ms_valid & mem_req & !buf_valid & !data_ok_acc;

    assign ms_allowin     = !ms_valid | (done & ws_allowin);
    assign ms_to_ws_valid = ms_valid & done & !ms_flush;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            bus_r <= '0;
        end else if (es_to_ms_valid && ms_allowin) begin
            bus_r <= es_to_ms_bus;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            ms_valid <= 1'b0;
        end else if (ms_flush) begin
            ms_valid <= 1'b0;
        end else if (ms_allowin) begin
            ms_valid <= es_to_ms_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            buf_valid <= 1'b0;
            buf_data  <= '0;
        end else if (ms_flush || (ms_to_ws_valid && ws_allowin)) begin
            buf_valid <= 1'b0;
        end else if (ms_valid && mem_req && !buf_valid && data_ok_acc && !ws_allowin) begin
            buf_valid <= 1'b1;
            buf_data  <= data_sram_rdata;
        end
    end

    // Flush with a simultaneous cancel-consume nets out to no change.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            cancel_cnt <= '0;
        end else if (cnt_inc && !cnt_dec) begin
            cancel_cnt <= cancel_cnt + CNT_W'(1);
        end else if (cnt_dec && !cnt_inc) begin
            cancel_cnt <= cancel_cnt - CNT_W'(1);
        end
    end

    assign raw = buf_valid ? buf_data : data_sram_rdata;

    mem_stage_lsu_load_align #(
        .DATA_W (DATA_W)
    ) u_load_align (
        .raw       (raw),
        .a         (alu_result[1:0]),
        .ld_op     (ld_op),
        .extracted (extracted)
    );

    assign final_result = res_from_mem ? extracted : alu_result;
    assign we           = ms_valid & gr_we;

    assign ms_to_ws_bus = {gr_we, dest, final_result, pc};
    assign ms_to_ds_bus = {ms_valid & res_from_mem & !done, we, dest,
                           we ? final_result : {DATA_W{1'b0}}};

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed bench for mem_stage_lsu: stimulus pushes expected WB results into a queue,
// a monitor pops and compares on each WB handshake.
module tb_mem_stage_lsu;

    localparam int PC_W = 32, DATA_W = 32, RF_AW = 5, CNT_W = 2;
    localparam int ES_W = 3 + 3 + RF_AW + DATA_W + PC_W;
    localparam int MS_W = 1 + RF_AW + DATA_W + PC_W;
    localparam int DS_W = RF_AW + DATA_W + 2;

    logic              clk = 1'b0;
    logic              resetn;
    logic              ws_allowin;
    logic              ms_allowin;
    logic              es_to_ms_valid;
    logic [ES_W-1:0]   es_to_ms_bus;
    logic              ms_flush;
    logic              data_sram_data_ok;
    logic [DATA_W-1:0] data_sram_rdata;
    logic              ms_to_ws_valid;
    logic [MS_W-1:0]   ms_to_ws_bus;
    logic [DS_W-1:0]   ms_to_ds_bus;

    int total = 0;
    int bad   = 0;
    logic [MS_W-1:0] exp_q[$];

    mem_stage_lsu #(.PC_W(PC_W), .DATA_W(DATA_W), .RF_AW(RF_AW), .CNT_W(CNT_W)) dut (
        .clk               (clk),
        .resetn            (resetn),
        .ws_allowin        (ws_allowin),
        .ms_allowin        (ms_allowin),
        .es_to_ms_valid    (es_to_ms_valid),
        .es_to_ms_bus      (es_to_ms_bus),
        .ms_flush          (ms_flush),
        .data_sram_data_ok (data_sram_data_ok),
        .data_sram_rdata   (data_sram_rdata),
        .ms_to_ws_valid    (ms_to_ws_valid),
        .ms_to_ws_bus      (ms_to_ws_bus),
        .ms_to_ds_bus      (ms_to_ds_bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (resetn) begin
            assert (!(dut.cnt_inc && !dut.cnt_dec && dut.cancel_cnt == '1))
                else $error("cancel counter overflow");
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every WB handshake must match the oldest expected entry.
    always @(negedge clk) begin
        if (resetn && ms_to_ws_valid && ws_allowin) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL wb_unexpected: got %h expected none", ms_to_ws_bus);
            end else begin
                logic [MS_W-1:0] e;
                e = exp_q.pop_front();
                if (ms_to_ws_bus !== e) begin
                    bad++;
                    $display("FAIL wb_bus: got %h expected %h", ms_to_ws_bus, e);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one instruction for a single cycle; optionally expect it at WB.
    task automatic issue(input logic [2:0] ld_op, input logic mreq, input logic rfm,
                         input logic [RF_AW-1:0] dest, input logic [31:0] alu,
                         input logic [31:0] pc, input logic push, input logic [31:0] res);
        es_to_ms_valid = 1'b1;
        es_to_ms_bus   = {ld_op, mreq, rfm, 1'b1, dest, alu, pc};
        if (push) exp_q.push_back({1'b1, dest, res, pc});
        tick();
        es_to_ms_valid = 1'b0;
        es_to_ms_bus   = '0;
    endtask

    task automatic load(input logic [2:0] ld_op, input logic [31:0] alu, input logic [31:0] rd,
                        input int delay, input logic [RF_AW-1:0] dest, input logic [31:0] res);
        issue(ld_op, 1'b1, 1'b1, dest, alu, 32'h400 + alu, 1'b1, res);
        for (int i = 0; i < delay; i++) begin
            @(negedge clk);
            chk("blocking_wait", 64'(ms_to_ds_bus[DS_W-1]), 64'd1);
            tick();
        end
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = rd;
        @(negedge clk);
        chk("load_ds_result", 64'(ms_to_ds_bus), 64'({1'b0, 1'b1, dest, res}));
        tick();
        data_sram_data_ok = 1'b0;
        data_sram_rdata   = '0;
    endtask

    initial begin
        resetn = 1'b0; ws_allowin = 1'b1; es_to_ms_valid = 1'b0; es_to_ms_bus = '0;
        ms_flush = 1'b0; data_sram_data_ok = 1'b0; data_sram_rdata = '0;
        tick(); tick();
        resetn = 1'b1;
        @(negedge clk);
        chk("rst_ws_valid", 64'(ms_to_ws_valid), 64'd0);
        chk("rst_allowin", 64'(ms_allowin), 64'd1);
        chk("rst_ds_bus", 64'(ms_to_ds_bus), 64'd0);
        tick();

        // ALU op: one-cycle occupancy
        issue(3'b000, 1'b0, 1'b0, 5'd3, 32'h1234_5678, 32'h100, 1'b1, 32'h1234_5678);
        @(negedge clk);
        chk("alu_valid", 64'(ms_to_ws_valid), 64'd1);
        chk("alu_ds_bus", 64'(ms_to_ds_bus), 64'({1'b0, 1'b1, 5'd3, 32'h1234_5678}));
        tick();
        @(negedge clk);
        chk("alu_gone", 64'(ms_to_ws_valid), 64'd0);

        // Sub-word loads
        load(3'b001, 32'h0000_1003, 32'h80FF_0000, 3, 5'd5, 32'hFFFF_FF80);
        load(3'b100, 32'h0000_1002, 32'h80FF_0000, 1, 5'd6, 32'h0000_80FF);
        load(3'b011, 32'h0000_1000, 32'h1234_8001, 0, 5'd7, 32'hFFFF_8001);
        load(3'b010, 32'h0000_1001, 32'h0000_F100, 2, 5'd8, 32'h0000_00F1);
        load(3'b111, 32'h0000_1000, 32'h0BAD_F00D, 0, 5'd9, 32'h0BAD_F00D);

        // Back-pressure: data captured into the buffer
        issue(3'b000, 1'b1, 1'b1, 5'd10, 32'h2000, 32'h200, 1'b1, 32'hCAFE_BABE);
        ws_allowin = 1'b0; data_sram_data_ok = 1'b1; data_sram_rdata = 32'hCAFE_BABE;
        @(negedge clk);
        chk("bp_valid", 64'(ms_to_ws_valid), 64'd1);
        tick();
        data_sram_data_ok = 1'b0; data_sram_rdata = '0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_hold_allowin", 64'(ms_allowin), 64'd0);
            chk("bp_buf_result", 64'(ms_to_ds_bus[DATA_W-1:0]), 64'h0000_0000_CAFE_BABE);
            tick();
        end
        ws_allowin = 1'b1;
        @(negedge clk);
        chk("bp_release", 64'(ms_to_ws_valid), 64'd1);
        tick();

        // Flush pending load; its late response must be swallowed
        issue(3'b000, 1'b1, 1'b1, 5'd11, 32'h3000, 32'h300, 1'b0, 32'h0);
        @(negedge clk);
        chk("fl_blocking", 64'(ms_to_ds_bus[DS_W-1]), 64'd1);
        tick();
        ms_flush = 1'b1;
        @(negedge clk);
        chk("fl_no_valid", 64'(ms_to_ws_valid), 64'd0);
        tick();
        ms_flush = 1'b0;
        issue(3'b000, 1'b1, 1'b1, 5'd12, 32'h3004, 32'h304, 1'b1, 32'h0000_BEEF);
        data_sram_data_ok = 1'b1; data_sram_rdata = 32'hDEAD_0000;
        @(negedge clk);
        chk("fl_stale_dropped", 64'(ms_to_ws_valid), 64'd0);
        chk("fl_still_blocking", 64'(ms_to_ds_bus[DS_W-1]), 64'd1);
        tick();
        data_sram_data_ok = 1'b0; data_sram_rdata = '0;
        @(negedge clk);
        chk("fl_wait", 64'(ms_to_ds_bus[DS_W-1]), 64'd1);
        tick();
        data_sram_data_ok = 1'b1; data_sram_rdata = 32'h0000_BEEF;
        @(negedge clk);
        chk("fl_new_valid", 64'(ms_to_ws_valid), 64'd1);
        tick();
        data_sram_data_ok = 1'b0; data_sram_rdata = '0;

        // Flush coinciding with data_ok: no cancel owed afterwards
        issue(3'b000, 1'b1, 1'b1, 5'd13, 32'h5000, 32'h500, 1'b0, 32'h0);
        ms_flush = 1'b1; data_sram_data_ok = 1'b1; data_sram_rdata = 32'h1111_1111;
        @(negedge clk);
        chk("flok_no_valid", 64'(ms_to_ws_valid), 64'd0);
        tick();
        ms_flush = 1'b0; data_sram_data_ok = 1'b0; data_sram_rdata = '0;
        load(3'b000, 32'h0000_5004, 32'h2222_2222, 0, 5'd14, 32'h2222_2222);

        // Reset mid-wait
        issue(3'b000, 1'b1, 1'b1, 5'd15, 32'h6000, 32'h600, 1'b0, 32'h0);
        @(negedge clk);
        chk("rw_blocking", 64'(ms_to_ds_bus[DS_W-1]), 64'd1);
        tick();
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        @(negedge clk);
        chk("rw_ws_valid", 64'(ms_to_ws_valid), 64'd0);
        chk("rw_allowin", 64'(ms_allowin), 64'd1);
        chk("rw_ds_bus", 64'(ms_to_ds_bus), 64'd0);
        tick();
        data_sram_data_ok = 1'b1; data_sram_rdata = 32'h5A5A_5A5A;
        @(negedge clk);
        chk("rw_stale_ok", 64'(ms_to_ws_valid), 64'd0);
        tick();
        data_sram_data_ok = 1'b0; data_sram_rdata = '0;

        tick(); tick();
        chk("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
